calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Top-level controller for the two-operand calculator datapath.
- Captures operand 1 and operand 2 from Din into register file entries RF[0] and RF[1] on successive button presses.
- On the next press, issues the selected mode to a multi-cycle ALU through a start/busy/done handshake, then writes the 2*DW-bit result back into RF[2] (low) and RF[3] (high).
- Also drives LED mux select, the done and error indicators, and a state debug bus.

Parameters:
- DW, 8, operand/data width.
- RF_AW, 3, register file address width.
- TIMEOUT, 255, maximum cycles in WAIT_ALU before error; counter width is $clog2(TIMEOUT+1).
- SYNC_STAGES, 2, flop stages in the button synchroniser (minimum 2).

Ports:
- CLK  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- next  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLK.
- MS  in  3  mode select, sampled in SEL_OP.
- Din  in  DW  switch data for operand entry.
- rf_we  out  1  register file write enable.
- rf_waddr  out  RF_AW  register file write address.
- rf_wdata  out  DW  register file write data.
- rf_raddr1  out  RF_AW  read port 1 address; constant 0.
- rf_raddr2  out  RF_AW  read port 2 address; constant 1.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_op  out  4  ALU opcode, {1'b0, MS latched}.
- alu_busy  in  1  ALU busy.
- alu_done  in  1  one-cycle result-valid pulse.
- alu_err  in  1  ALU error (e.g. divide by zero); qualified by alu_done.
- alu_result  in  2*DW  ALU result.
- LEDsel  out  2  LED mux select.
- Done_out  out  1  result available.
- Err_out  out  1  error latched.
- cs_out  out  4  current state encoding.

Behaviour:
- Reset (clear=0, async):
  - state = IDLE1.
  - Synchroniser flops = 1 (released).
  - All outputs 0, except rf_raddr2 = 1.
- Button input:
  - next passes through SYNC_STAGES flops.
  - A press is a one-cycle pulse on the synchronised 1->0 transition. Holding the button yields exactly one press.
- States (cs_out encoding):
  - IDLE1=0: LEDsel=00. press -> LOAD1.
  - LOAD1=1: rf_we=1, waddr=0, wdata=Din. -> IDLE2 next cycle.
  - IDLE2=2: LEDsel=00. press -> LOAD2.
  - LOAD2=3: rf_we=1, waddr=1, wdata=Din. -> SEL_OP.
  - SEL_OP=4: LEDsel=01; alu_op tracks MS live. On press, latch MS -> ISSUE.
  - ISSUE=5: if alu_busy=0, assert alu_start for one cycle -> WAIT_ALU; else stay in ISSUE with no start.
  - WAIT_ALU=6: timeout counter increments each cycle.
    - alu_done=1 with alu_err=0 -> capture alu_result -> WB_LO.
    - alu_done=1 with alu_err=1 -> ERROR.
    - counter reaches TIMEOUT with no alu_done -> ERROR.
    - If alu_done arrives in the same cycle the counter reaches TIMEOUT, alu_done wins.
  - WB_LO=7: rf_we=1, waddr=2, wdata=result[DW-1:0]. -> WB_HI.
  - WB_HI=8: rf_we=1, waddr=3, wdata=result[2*DW-1:DW]. -> DONE.
  - DONE=9: Done_out=1, LEDsel=10; terminal.
  - ERROR=10: Err_out=1, LEDsel=11; terminal.
  - Unused encodings -> IDLE1 with all outputs at their reset values.
- Press handling:
  - Presses in any state other than IDLE1, IDLE2, SEL_OP, and DONE (with CHAIN_EN) are ignored; they are not queued.
- Output timing:
  - rf_we, rf_waddr, rf_wdata, alu_start, Done_out, Err_out, LEDsel are registered: they change on the clock edge entering the state.
- Latency:
  - From the press in SEL_OP to alu_start is 2 cycles when the ALU is idle.
  - From alu_done to Done_out is 3 cycles.
- Timeout counter clears on entry to WAIT_ALU.
- Mid-operation reset (clear asserted in any state) aborts immediately:
  - alu_start and rf_we drop asynchronously.
  - An in-flight ALU result is discarded.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: in DONE, a press writes result[DW-1:0] into RF[0] (rf_we=1, waddr=0, one cycle), clears Done_out, then goes to IDLE2. This supports accumulate-style chaining.
- Undefined: DONE is terminal until reset; presses there are ignored.

Decomposition:
- Shared package calc_pkg holds:
  - state enum/localparams (codes 0-10);
  - RF address constants RF_OP1=0, RF_OP2=1, RF_RES_LO=2, RF_RES_HI=3;
  - LEDsel codes LED_DIN=00, LED_MS=01, LED_RES=10, LED_ERR=11.
- Sub-module btn_sync_edge: synchroniser plus falling-edge press pulse, parameterised on SYNC_STAGES. It is reused by other button inputs in the design.

Test Plan:
- Reset with next held low -> no press generated; state stays IDLE1 until next is released and pressed again.
- Din=8'h12 press, Din=8'h34 press, MS=3'b001 press; ALU model returns 16'h0046 after 4 cycles -> RF[0]=12, RF[1]=34, RF[2]=46, RF[3]=00; Done_out=1 exactly 3 cycles after alu_done; alu_start is exactly one pulse.
- alu_busy held high for 10 cycles at ISSUE -> no alu_start until busy falls, then a single pulse.
- ALU never returns alu_done -> Err_out=1 and LEDsel=11 at TIMEOUT+1 cycles after alu_start; no RF writes.
- alu_done with alu_err=1 -> ERROR state; RF[2] and RF[3] unchanged.
- clear pulsed low during WAIT_ALU, then late alu_done -> outputs reset asynchronously; the late alu_done is ignored in IDLE1. With CALC_CHAIN_EN, a press in DONE writes RF[0]=result low byte and gives cs_out=2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state codes, register-file slots and LED mux codes.
// Optional build macro used by the sequencer: CALC_CHAIN_EN.
package calc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE1    = 4'd0,
        ST_LOAD1    = 4'd1,
        ST_IDLE2    = 4'd2,
        ST_LOAD2    = 4'd3,
        ST_SEL_OP   = 4'd4,
        ST_ISSUE    = 4'd5,
        ST_WAIT_ALU = 4'd6,
        ST_WB_LO    = 4'd7,
        ST_WB_HI    = 4'd8,
        ST_DONE     = 4'd9,
        ST_ERROR    = 4'd10
    } state_t;

    localparam int unsigned RF_OP1    = 0;
    localparam int unsigned RF_OP2    = 1;
    localparam int unsigned RF_RES_LO = 2;
    localparam int unsigned RF_RES_HI = 3;

    localparam logic [1:0] LED_DIN = 2'b00;
    localparam logic [1:0] LED_MS  = 2'b01;
    localparam logic [1:0] LED_RES = 2'b10;
    localparam logic [1:0] LED_ERR = 2'b11;

    function automatic logic [3:0] make_alu_op(input logic [2:0] ms);
        return {1'b0, ms};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Pushbutton synchroniser with a one-cycle press pulse on the synchronised 1->0 transition.
// The chain resets to "released"; presses are only armed once the chain holds real samples.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic clear,
    input  logic btn_n,
    output logic press
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] flush_reg;
    logic              prev_reg;

    // prev_reg stays 0 until the chain has flushed its reset value, so a button
    // already held down when reset releases never produces a press.
    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) begin
            sync_reg  <= '1;
            flush_reg <= '0;
            prev_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[STAGES-2:0], btn_n};
            flush_reg <= {flush_reg[STAGES-2:0], 1'b1};
            prev_reg  <= flush_reg[STAGES-1] & sync_reg[STAGES-1];
        end
    end

    assign press = prev_reg & ~sync_reg[STAGES-1];

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator controller: operand entry, ALU issue/handshake with timeout, result write-back.
// Define CALC_CHAIN_EN to let a press in DONE feed the result back as operand 1.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DW          = 8,
    parameter int RF_AW       = 3,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              clear,
    input  logic              next,
    input  logic [2:0]        MS,
    input  logic [DW-1:0]     Din,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [RF_AW-1:0]  rf_raddr1,
    output logic [RF_AW-1:0]  rf_raddr2,
    output logic              alu_start,
    output logic [3:0]        alu_op,
    input  logic              alu_busy,
    input  logic              alu_done,
    input  logic              alu_err,
    input  logic [2*DW-1:0]   alu_result,
    output logic [1:0]        LEDsel,
    output logic              Done_out,
    output logic              Err_out,
    output logic [3:0]        cs_out
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic              press;
    state_t            state_reg;
    logic [2:0]        ms_reg;
    logic [2*DW-1:0]   result_reg;
    logic [TW-1:0]     tmo_cnt_reg;
    logic              rf_we_reg;
    logic [RF_AW-1:0]  rf_waddr_reg;
    logic [DW-1:0]     rf_wdata_reg;
    logic              alu_start_reg;
    logic [1:0]        led_reg;
    logic              done_reg;
    logic              err_reg;

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_next_sync (
        .CLK   (CLK),
        .clear (clear),
        .btn_n (next),
        .press (press)
    );

    // Outputs are set on the transition into a state, so they are valid for
    // the whole first cycle of that state.
    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) begin
            state_reg     <= ST_IDLE1;
            ms_reg        <= '0;
            result_reg    <= '0;
            tmo_cnt_reg   <= '0;
            rf_we_reg     <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            alu_start_reg <= 1'b0;
            led_reg       <= LED_DIN;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            rf_we_reg     <= 1'b0;
            alu_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE1: begin
                    if (press) begin
                        state_reg    <= ST_LOAD1;
                        rf_we_reg    <= 1'b1;
                        rf_waddr_reg <= RF_AW'(RF_OP1);
                        rf_wdata_reg <= Din;
                    end
                end
                ST_LOAD1: begin
                    state_reg <= ST_IDLE2;
                    led_reg   <= LED_DIN;
                end
                ST_IDLE2: begin
                    if (press) begin
                        state_reg    <= ST_LOAD2;
                        rf_we_reg    <= 1'b1;
                        rf_waddr_reg <= RF_AW'(RF_OP2);
                        rf_wdata_reg <= Din;
                    end
                end
                ST_LOAD2: begin
                    state_reg <= ST_SEL_OP;
                    led_reg   <= LED_MS;
                end
                ST_SEL_OP: begin
                    if (press) begin
                        ms_reg    <= MS;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!alu_busy) begin
                        state_reg     <= ST_WAIT_ALU;
                        alu_start_reg <= 1'b1;
                        tmo_cnt_reg   <= '0;
                    end
                end
                ST_WAIT_ALU: begin
                    // alu_done is checked before the timeout so a result that
                    // lands on the last allowed cycle is still accepted.
                    if (alu_done) begin
                        if (alu_err) begin
                            state_reg <= ST_ERROR;
                            err_reg   <= 1'b1;
                            led_reg   <= LED_ERR;
                        end else begin
                            result_reg   <= alu_result;
                            state_reg    <= ST_WB_LO;
                            rf_we_reg    <= 1'b1;
                            rf_waddr_reg <= RF_AW'(RF_RES_LO);
                            rf_wdata_reg <= alu_result[DW-1:0];
                        end
                    end else if (tmo_cnt_reg == TW'(TIMEOUT)) begin
                        state_reg <= ST_ERROR;
                        err_reg   <= 1'b1;
                        led_reg   <= LED_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                ST_WB_LO: begin
                    state_reg    <= ST_WB_HI;
                    rf_we_reg    <= 1'b1;
                    rf_waddr_reg <= RF_AW'(RF_RES_HI);
                    rf_wdata_reg <= result_reg[2*DW-1:DW];
                end
                ST_WB_HI: begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                    led_reg   <= LED_RES;
                end
                ST_DONE: begin
`ifdef CALC_CHAIN_EN
                    if (press) begin
                        state_reg    <= ST_IDLE2;
                        rf_we_reg    <= 1'b1;
                        rf_waddr_reg <= RF_AW'(RF_OP1);
                        rf_wdata_reg <= result_reg[DW-1:0];
                        done_reg     <= 1'b0;
                        led_reg      <= LED_DIN;
                    end
`else
                    state_reg <= ST_DONE;
`endif
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg     <= ST_IDLE1;
                    ms_reg        <= '0;
                    result_reg    <= '0;
                    tmo_cnt_reg   <= '0;
                    rf_waddr_reg  <= '0;
                    rf_wdata_reg  <= '0;
                    led_reg       <= LED_DIN;
                    done_reg      <= 1'b0;
                    err_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign rf_we     = rf_we_reg;
    assign rf_waddr  = rf_waddr_reg;
    assign rf_wdata  = rf_wdata_reg;
    assign rf_raddr1 = RF_AW'(RF_OP1);
    assign rf_raddr2 = RF_AW'(RF_OP2);
    assign alu_start = alu_start_reg;
    assign alu_op    = (state_reg == ST_SEL_OP) ? make_alu_op(MS) : make_alu_op(ms_reg);
    assign LEDsel    = led_reg;
    assign Done_out  = done_reg;
    assign Err_out   = err_reg;
    assign cs_out    = state_reg;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer; the DONE-press step follows CALC_CHAIN_EN.
module tb_calc_op_sequencer;

    localparam int DW      = 8;
    localparam int RF_AW   = 3;
    localparam int TIMEOUT = 255;

    logic              CLK = 1'b0;
    logic              clear;
    logic              next;
    logic [2:0]        MS;
    logic [DW-1:0]     Din;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [RF_AW-1:0]  rf_raddr1;
    logic [RF_AW-1:0]  rf_raddr2;
    logic              alu_start;
    logic [3:0]        alu_op;
    logic              alu_busy;
    logic              alu_done;
    logic              alu_err;
    logic [2*DW-1:0]   alu_result;
    logic [1:0]        LEDsel;
    logic              Done_out;
    logic              Err_out;
    logic [3:0]        cs_out;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int wr_base;
    int st_base;
    logic [DW-1:0] rf_model [0:7] = '{default: '0};

    calc_op_sequencer #(
        .DW          (DW),
        .RF_AW       (RF_AW),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .CLK        (CLK),
        .clear      (clear),
        .next       (next),
        .MS         (MS),
        .Din        (Din),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_busy   (alu_busy),
        .alu_done   (alu_done),
        .alu_err    (alu_err),
        .alu_result (alu_result),
        .LEDsel     (LEDsel),
        .Done_out   (Done_out),
        .Err_out    (Err_out),
        .cs_out     (cs_out)
    );

    always #5 CLK = ~CLK;

    // Register file as the rest of the datapath would see it.
    always @(posedge CLK) begin
        if (rf_we === 1'b1) begin
            rf_model[rf_waddr] <= rf_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_btn();
        next = 1'b0;
        tick(4);
        next = 1'b1;
        tick(4);
    endtask

    task automatic do_reset();
        clear = 1'b0;
        tick(2);
        clear = 1'b1;
        tick(4);
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (alu_start !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check(tag, 32'(alu_start), 32'd1);
    endtask

    task automatic load_ops(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] ms);
        Din = a;
        press_btn();
        Din = b;
        press_btn();
        MS = ms;
    endtask

    initial begin
        clear = 1'b0; next = 1'b0; MS = '0; Din = '0;
        alu_busy = 1'b0; alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
        tick(3);
        check("rst_cs", 32'(cs_out), 32'd0);
        check("rst_raddr2", 32'(rf_raddr2), 32'd1);
        check("rst_raddr1", 32'(rf_raddr1), 32'd0);
        check("rst_outs", {24'd0, rf_we, alu_start, Done_out, Err_out, LEDsel, 2'b00}, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);

        // Button held through reset release must not produce a press.
        clear = 1'b1;
        tick(10);
        check("held_no_press", 32'(cs_out), 32'd0);
        next = 1'b1;
        tick(5);
        check("release_no_press", 32'(cs_out), 32'd0);

        // Main operation: 12, 34, mode 1, result 0x0046.
        wr_base = wr_cnt; st_base = start_cnt;
        Din = 8'h12;
        press_btn();
        check("op1_cs", 32'(cs_out), 32'd2);
        check("op1_rf0", 32'(rf_model[0]), 32'h12);
        Din = 8'h34;
        press_btn();
        check("op2_cs", 32'(cs_out), 32'd4);
        check("op2_led", 32'(LEDsel), 32'd1);
        check("op2_rf1", 32'(rf_model[1]), 32'h34);
        MS = 3'b101; #1;
        check("ms_live_5", 32'(alu_op), 32'h5);
        MS = 3'b001; #1;
        check("ms_live_1", 32'(alu_op), 32'h1);
        next = 1'b0;
        tick(3);
        check("issue_cs", 32'(cs_out), 32'd5);
        check("issue_nostart", 32'(alu_start), 32'd0);
        tick();
        check("start_lat_cs", 32'(cs_out), 32'd6);
        check("start_lat", 32'(alu_start), 32'd1);
        next = 1'b1; MS = 3'b111;
        tick();
        check("start_one_pulse", 32'(alu_start), 32'd0);
        check("ms_latched", 32'(alu_op), 32'h1);
        alu_busy = 1'b1;
        tick(3);
        alu_busy = 1'b0; alu_done = 1'b1; alu_result = 16'h0046;
        tick();
        alu_done = 1'b0; alu_result = 16'hFFFF;
        check("wblo_cs", 32'(cs_out), 32'd7);
        check("wblo_we_addr", {rf_we, 28'd0, rf_waddr}, {1'b1, 28'd0, 3'd2});
        check("wblo_data", 32'(rf_wdata), 32'h46);
        tick();
        check("wbhi_cs", 32'(cs_out), 32'd8);
        check("wbhi_addr_data", {21'd0, rf_waddr, rf_wdata}, {21'd0, 3'd3, 8'h00});
        check("done_not_early", 32'(Done_out), 32'd0);
        tick();
        check("done_lat", 32'(Done_out), 32'd1);
        check("done_led", 32'(LEDsel), 32'd2);
        check("done_cs", 32'(cs_out), 32'd9);
        tick();
        check("rf2", 32'(rf_model[2]), 32'h46);
        check("rf3", 32'(rf_model[3]), 32'h00);
        check("main_starts", 32'(start_cnt - st_base), 32'd1);
        check("main_writes", 32'(wr_cnt - wr_base), 32'd4);

        // Press in DONE.
        wr_base = wr_cnt;
        press_btn();
`ifdef CALC_CHAIN_EN
        check("chain_cs", 32'(cs_out), 32'd2);
        check("chain_rf0", 32'(rf_model[0]), 32'h46);
        check("chain_done_clr", 32'(Done_out), 32'd0);
`else
        check("done_terminal_cs", 32'(cs_out), 32'd9);
        check("done_terminal_wr", 32'(wr_cnt - wr_base), 32'd0);
        check("done_terminal_flag", 32'(Done_out), 32'd1);
`endif

        // Busy ALU holds ISSUE, then a single start; then timeout.
        do_reset();
        wr_base = wr_cnt; st_base = start_cnt;
        load_ops(8'h07, 8'h03, 3'b010);
        alu_busy = 1'b1;
        next = 1'b0;
        tick(3);
        next = 1'b1;
        tick(10);
        check("busy_cs", 32'(cs_out), 32'd5);
        check("busy_nostart", 32'(start_cnt - st_base), 32'd0);
        alu_busy = 1'b0;
        tick();
        check("busy_start", 32'(alu_start), 32'd1);
        tick();
        check("busy_single", 32'(alu_start), 32'd0);
        tick(TIMEOUT - 1);
        check("tmo_edge_cs", 32'(cs_out), 32'd6);
        check("tmo_edge_err", 32'(Err_out), 32'd0);
        tick();
        check("tmo_err", 32'(Err_out), 32'd1);
        check("tmo_led", 32'(LEDsel), 32'd3);
        check("tmo_cs", 32'(cs_out), 32'd10);
        check("tmo_writes", 32'(wr_cnt - wr_base), 32'd2);
        check("tmo_starts", 32'(start_cnt - st_base), 32'd1);

        // ALU reports an error.
        do_reset();
        wr_base = wr_cnt;
        load_ops(8'h05, 8'h00, 3'b011);
        next = 1'b0;
        wait_start("err_start");
        next = 1'b1;
        tick(2);
        alu_done = 1'b1; alu_err = 1'b1; alu_result = 16'h1234;
        tick();
        alu_done = 1'b0; alu_err = 1'b0;
        check("aluerr_cs", 32'(cs_out), 32'd10);
        check("aluerr_flag", 32'(Err_out), 32'd1);
        tick(3);
        check("aluerr_rf2", 32'(rf_model[2]), 32'h46);
        check("aluerr_rf3", 32'(rf_model[3]), 32'h00);
        check("aluerr_writes", 32'(wr_cnt - wr_base), 32'd2);

        // Clear during WAIT_ALU, late alu_done ignored.
        do_reset();
        load_ops(8'h21, 8'h43, 3'b000);
        next = 1'b0;
        wait_start("clr_start");
        next = 1'b1;
        clear = 1'b0;
        #1;
        check("clr_start_drop", 32'(alu_start), 32'd0);
        check("clr_cs", 32'(cs_out), 32'd0);
        tick(2);
        clear = 1'b1;
        tick(4);
        wr_base = wr_cnt;
        alu_done = 1'b1; alu_result = 16'hBEEF;
        tick();
        alu_done = 1'b0;
        tick();
        check("late_done_cs", 32'(cs_out), 32'd0);
        check("late_done_wr", 32'(wr_cnt - wr_base), 32'd0);

        // Clear during result write-back drops rf_we at once.
        load_ops(8'h01, 8'h02, 3'b000);
        next = 1'b0;
        wait_start("clrwb_start");
        next = 1'b1;
        alu_done = 1'b1; alu_result = 16'h0003;
        tick();
        alu_done = 1'b0;
        check("clrwb_we_before", 32'(rf_we), 32'd1);
        clear = 1'b0;
        #1;
        check("clrwb_we_drop", 32'(rf_we), 32'd0);
        tick(2);
        clear = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
